// File: rtl/lt24_rect_fill_pkg.sv
// rtl/lt24_rect_fill_pkg.sv - shared types and constants for the LT24 rectangle fill block
package lt24_pkg;

    localparam int WIDTH_DEF  = 240;
    localparam int HEIGHT_DEF = 320;
    localparam int X_W        = 8;
    localparam int Y_W        = 9;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/lt24_rect_fill_if.sv
// rtl/lt24_rect_fill_if.sv - command and pixel handshake bundle between app, fill block and LT24 driver
interface lt24_rect_fill_if;
    import lt24_pkg::*;

    logic             cmdValid;
    logic             cmdReady;
    logic [X_W-1:0]   cmdX;
    logic [Y_W-1:0]   cmdY;
    logic [X_W-1:0]   cmdW;
    logic [Y_W-1:0]   cmdH;
    rgb565_t          cmdColour;

    logic [X_W-1:0]   xAddr;
    logic [Y_W-1:0]   yAddr;
    rgb565_t          pixelData;
    logic             pixelWrite;
    logic             pixelReady;

    // Side that issues commands and plays the display driver.
    modport master (
        output cmdValid, cmdX, cmdY, cmdW, cmdH, cmdColour, pixelReady,
        input  cmdReady, xAddr, yAddr, pixelData, pixelWrite
    );

    // The fill block itself.
    modport slave (
        input  cmdValid, cmdX, cmdY, cmdW, cmdH, cmdColour, pixelReady,
        output cmdReady, xAddr, yAddr, pixelData, pixelWrite
    );

endinterface

// File: rtl/lt24_rect_fill_raster_counter.sv
// rtl/lt24_rect_fill_raster_counter.sv - loadable raster-order x/y counter over a clipped rectangle
module lt24_raster_counter
    import lt24_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [X_W-1:0]   start_x_i,
    input  logic [Y_W-1:0]   start_y_i,
    input  logic [X_W-1:0]   x_last_i,
    input  logic [Y_W-1:0]   y_last_i,
    input  logic             advance_i,
    output logic [X_W-1:0]   x_o,
    output logic [Y_W-1:0]   y_o,
    output logic             last_o
);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [X_W-1:0] x_start_q, x_start_d;
    logic [X_W-1:0] x_last_q, x_last_d;
    logic [Y_W-1:0] y_last_q, y_last_d;

    assign last_o = (x_q == x_last_q) && (y_q == y_last_q);
    assign x_o    = x_q;
    assign y_o    = y_q;

    // Load a new rectangle, or step one pixel in raster order; holds at the final pixel.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        x_start_d = x_start_q;
        x_last_d  = x_last_q;
        y_last_d  = y_last_q;
        if (load_i) begin
            x_d       = start_x_i;
            y_d       = start_y_i;
            x_start_d = start_x_i;
            x_last_d  = x_last_i;
            y_last_d  = y_last_i;
        end else if (advance_i && !last_o) begin
            if (x_q < x_last_q) begin
                x_d = x_q + 1'b1;
            end else begin
                x_d = x_start_q;
                y_d = y_q + 1'b1;
            end
        end
    end

    // Counter and bound registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q       <= '0;
            y_q       <= '0;
            x_start_q <= '0;
            x_last_q  <= '0;
            y_last_q  <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            x_start_q <= x_start_d;
            x_last_q  <= x_last_d;
            y_last_q  <= y_last_d;
        end
    end

endmodule

// File: rtl/lt24_rect_fill.sv
// rtl/lt24_rect_fill.sv - clipped rectangle fill streaming pixels to the LT24 driver
module lt24_rect_fill
    import lt24_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF
) (
    input  logic                clock,
    input  logic                reset_n,
    lt24_rect_fill_if.slave     bus,
    output logic                busy,
    output logic                done
);

    // Panel limits widened one bit so origin+size never wraps before clipping.
    localparam logic [X_W:0] W_LIM = (X_W+1)'(WIDTH);
    localparam logic [Y_W:0] H_LIM = (Y_W+1)'(HEIGHT);

    state_e         state_q, state_d;
    logic           ready_q;
    rgb565_t        colour_q, colour_d;

    logic           accept;
    logic           cmd_empty;
    logic           load;
    logic           advance;
    logic           last;
    logic [X_W:0]   x_end, x_lim;
    logic [Y_W:0]   y_end, y_lim;
    logic [X_W-1:0] x_last;
    logic [Y_W-1:0] y_last;
    logic [X_W-1:0] cnt_x;
    logic [Y_W-1:0] cnt_y;

    // Clip the incoming command to the panel and flag commands that cover no pixel.
    always_comb begin
        x_end     = {1'b0, bus.cmdX} + {1'b0, bus.cmdW};
        y_end     = {1'b0, bus.cmdY} + {1'b0, bus.cmdH};
        x_lim     = (x_end > W_LIM) ? W_LIM : x_end;
        y_lim     = (y_end > H_LIM) ? H_LIM : y_end;
        x_last    = X_W'(x_lim - 1'b1);
        y_last    = Y_W'(y_lim - 1'b1);
        cmd_empty = (bus.cmdW == '0) || (bus.cmdH == '0) ||
                    ({1'b0, bus.cmdX} >= W_LIM) || ({1'b0, bus.cmdY} >= H_LIM);
    end

    // ready_q keeps cmdReady low until the first clock edge after reset releases.
    assign bus.cmdReady  = (state_q == IDLE) && ready_q;
    assign accept        = bus.cmdReady && bus.cmdValid;
    assign load          = accept && !cmd_empty;
    assign advance       = (state_q == FILL) && bus.pixelReady;

    assign bus.pixelWrite = (state_q == FILL);
    assign bus.pixelData  = colour_q;
    assign bus.xAddr      = cnt_x;
    assign bus.yAddr      = cnt_y;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);

    // FSM next state: empty commands skip straight to DONE; the last accepted pixel ends FILL.
    always_comb begin
        state_d  = state_q;
        colour_d = colour_q;
        if (load) begin
            colour_d = bus.cmdColour;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = cmd_empty ? DONE : FILL;
                end
            end
            FILL: begin
                if (bus.pixelReady && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, post-reset ready flag and latched fill colour.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= 1'b1;
            colour_q <= colour_d;
        end
    end

    lt24_raster_counter u_counter (
        .clock     (clock),
        .reset_n   (reset_n),
        .load_i    (load),
        .start_x_i (bus.cmdX),
        .start_y_i (bus.cmdY),
        .x_last_i  (x_last),
        .y_last_i  (y_last),
        .advance_i (advance),
        .x_o       (cnt_x),
        .y_o       (cnt_y),
        .last_o    (last)
    );

endmodule

// File: tb/tb_lt24_rect_fill.sv
// tb/tb_lt24_rect_fill.sv - directed self-checking bench for lt24_rect_fill
module tb_lt24_rect_fill;
    import lt24_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    logic busy;
    logic done;

    lt24_rect_fill_if bus ();

    lt24_rect_fill #(.WIDTH(240), .HEIGHT(320)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    int n_tests    = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int done_total = 0;

    logic [7:0]  px_x[$];
    logic [8:0]  px_y[$];
    logic [15:0] px_d[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Record every pixel the driver is about to accept, and every done pulse.
    always @(negedge clock) begin
        if (bus.pixelWrite === 1'b1 && bus.pixelReady === 1'b1) begin
            px_x.push_back(bus.xAddr);
            px_y.push_back(bus.yAddr);
            px_d.push_back(bus.pixelData);
        end
        if (done === 1'b1) done_total <= done_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic clear_q();
        px_x.delete();
        px_y.delete();
        px_d.delete();
    endtask

    task automatic send_cmd(input int x, input int y, input int w, input int h,
                            input logic [15:0] c, output int acc);
        bit ok = 0;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.cmdReady === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("cmd_ready_timeout", 0, 1);
        end else begin
            bus.cmdX      = 8'(x);
            bus.cmdY      = 9'(y);
            bus.cmdW      = 8'(w);
            bus.cmdH      = 9'(h);
            bus.cmdColour = c;
            bus.cmdValid  = 1'b1;
            acc = cyc;
            @(posedge clock);
            #1;
            bus.cmdValid = 1'b0;
        end
    endtask

    task automatic wait_done(input int maxc, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
    endtask

    // Compare recorded pixels from index base against the expected raster walk.
    task automatic check_rect(input int base, input int x0, input int y0, input int x1,
                              input int y1, input logic [15:0] c, output int bad);
        int k = base;
        bad = 0;
        for (int yy = y0; yy <= y1; yy++) begin
            for (int xx = x0; xx <= x1; xx++) begin
                if (k >= px_x.size()) bad++;
                else if (px_x[k] != 8'(xx) || px_y[k] != 9'(yy) || px_d[k] != c) bad++;
                k++;
            end
        end
    endtask

    initial begin
        int a, a2, d, d2, bad, oob, stalls;
        int nacc, acc1, acc2, done1, dt0;
        logic prev_stall;
        logic [7:0]  sx;
        logic [8:0]  sy;
        logic [15:0] sd;

        bus.cmdValid   = 1'b0;
        bus.cmdX       = '0;
        bus.cmdY       = '0;
        bus.cmdW       = '0;
        bus.cmdH       = '0;
        bus.cmdColour  = '0;
        bus.pixelReady = 1'b1;

        // Reset values, applied asynchronously.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_cmdReady",   bus.cmdReady,   0);
        chk("rst_pixelWrite", bus.pixelWrite, 0);
        chk("rst_busy",       busy,           0);
        chk("rst_done",       done,           0);
        chk("rst_xAddr",      bus.xAddr,      0);
        chk("rst_yAddr",      bus.yAddr,      0);
        chk("rst_pixelData",  bus.pixelData,  0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rel_cmdReady_low", bus.cmdReady, 0);
        @(posedge clock);
        #1;
        chk("rel_cmdReady_high", bus.cmdReady, 1);

        // Full-screen clear.
        clear_q();
        send_cmd(0, 0, 240, 320, 16'hF800, a);
        wait_done(80000, d);
        chk("full_count", px_x.size(), 76800);
        check_rect(0, 0, 0, 239, 319, 16'hF800, bad);
        chk("full_raster", bad, 0);
        chk("full_latency", d - a, 76801);

        // Bottom-right corner clipped to 10x5.
        clear_q();
        send_cmd(230, 315, 20, 10, 16'h07E0, a);
        wait_done(200, d);
        chk("clip_count", px_x.size(), 50);
        check_rect(0, 230, 315, 239, 319, 16'h07E0, bad);
        chk("clip_raster", bad, 0);
        oob = 0;
        foreach (px_x[i]) if (px_x[i] >= 8'd240 || px_y[i] >= 9'd320) oob++;
        chk("clip_oob", oob, 0);
        chk("clip_latency", d - a, 51);

        // Alternating pixelReady: outputs hold while stalled.
        clear_q();
        send_cmd(5, 5, 3, 2, 16'h1F1F, a);
        bad = 0;
        stalls = 0;
        prev_stall = 1'b0;
        d = -1;
        sx = '0; sy = '0; sd = '0;
        for (int k = 0; k < 40; k++) begin
            bus.pixelReady = (k % 2 == 0);
            @(negedge clock);
            if (done === 1'b1) begin
                d = cyc;
                break;
            end
            if (prev_stall) begin
                if (bus.pixelWrite !== 1'b1 || bus.xAddr !== sx || bus.yAddr !== sy ||
                    bus.pixelData !== sd) bad++;
            end
            prev_stall = bus.pixelWrite && !bus.pixelReady;
            if (prev_stall) stalls++;
            sx = bus.xAddr;
            sy = bus.yAddr;
            sd = bus.pixelData;
            @(posedge clock);
            #1;
        end
        bus.pixelReady = 1'b1;
        chk("stall_stable", bad, 0);
        chk("stall_cycles", stalls, 5);
        chk("stall_count", px_x.size(), 6);
        check_rect(0, 5, 5, 7, 6, 16'h1F1F, bad);
        chk("stall_raster", bad, 0);
        chk("stall_latency", d - a, 12);

        // Empty commands: zero width, origin past right edge, origin past bottom edge.
        clear_q();
        send_cmd(0, 0, 0, 5, 16'hFFFF, a);
        wait_done(20, d);
        chk("empty_w_latency", d - a, 1);
        send_cmd(240, 0, 4, 4, 16'hFFFF, a);
        wait_done(20, d);
        chk("empty_x_latency", d - a, 1);
        send_cmd(0, 320, 4, 4, 16'hFFFF, a);
        wait_done(20, d);
        chk("empty_y_latency", d - a, 1);
        chk("empty_pixels", px_x.size(), 0);

        // cmdValid held high across a 4-pixel fill.
        clear_q();
        nacc = 0; acc1 = -1; acc2 = -1; done1 = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.cmdReady === 1'b1) break;
        end
        bus.cmdX = 8'd0; bus.cmdY = 9'd0; bus.cmdW = 8'd4; bus.cmdH = 9'd1;
        bus.cmdColour = 16'hAAAA;
        bus.cmdValid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clock);
            if (bus.cmdValid && bus.cmdReady === 1'b1) begin
                nacc++;
                if (nacc == 1) acc1 = cyc;
                else acc2 = cyc;
            end
            if (done === 1'b1) done1 = cyc;
            @(posedge clock);
            #1;
            if (nacc == 1) begin
                bus.cmdX = 8'd10; bus.cmdY = 9'd10; bus.cmdW = 8'd2; bus.cmdH = 9'd1;
                bus.cmdColour = 16'h5555;
            end
            if (nacc == 2) break;
        end
        bus.cmdValid = 1'b0;
        wait_done(50, d2);
        chk("hold_accepts", nacc, 2);
        chk("hold_gap", acc2 - acc1, 6);
        chk("hold_after_done", acc2 - done1, 1);
        chk("hold_latency2", d2 - acc2, 3);
        chk("hold_count", px_x.size(), 6);
        check_rect(0, 0, 0, 3, 0, 16'hAAAA, bad);
        chk("hold_raster1", bad, 0);
        check_rect(4, 10, 10, 11, 10, 16'h5555, bad);
        chk("hold_raster2", bad, 0);

        // Reset pulsed mid-fill.
        clear_q();
        send_cmd(0, 0, 20, 1, 16'h1234, a);
        repeat (5) @(negedge clock);
        dt0 = done_total;
        reset_n = 1'b0;
        #1;
        chk("midrst_pixelWrite", bus.pixelWrite, 0);
        chk("midrst_busy",       busy,           0);
        chk("midrst_cmdReady",   bus.cmdReady,   0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("midrst_no_done", done_total - dt0, 0);
        clear_q();
        send_cmd(100, 100, 2, 2, 16'hBEEF, a2);
        wait_done(50, d);
        chk("postrst_latency", d - a2, 5);
        chk("postrst_count", px_x.size(), 4);
        check_rect(0, 100, 100, 101, 101, 16'hBEEF, bad);
        chk("postrst_raster", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lt24_rect_fill.md
# lt24_rect_fill

Rectangle-fill pixel generator sitting directly upstream of the LT24 display driver. Accepts one fill command (origin, size, RGB565 colour), clips it to the panel, and streams every covered pixel in raster order over the driver's `pixelWrite`/`pixelReady` handshake. Used by top-level apps for screen clears, backgrounds and UI blocks without per-pixel software involvement.

## Interface
- `WIDTH`, default 240: panel width in pixels.
- `HEIGHT`, default 320: panel height in pixels.

Ports:
- `clock`  in  1: system clock, all logic on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cmdValid`  in  1: command present.
- `cmdReady`  out  1: block can accept a command.
- `cmdX`  in  8: left column.
- `cmdY`  in  9: top row.
- `cmdW`  in  8: width in pixels, 0 = empty.
- `cmdH`  in  9: height in pixels, 0 = empty.
- `cmdColour`  in  16: RGB565 fill colour.
- `xAddr`  out  8: pixel column to driver.
- `yAddr`  out  9: pixel row to driver.
- `pixelData`  out  16: pixel colour to driver.
- `pixelWrite`  out  1: pixel valid to driver.
- `pixelReady`  in  1: driver accepts pixel this cycle.
- `busy`  out  1: fill in progress.
- `done`  out  1: one-cycle pulse when a command completes.

## Operation
- States:
  - IDLE: `cmdReady`=1.
  - FILL: `pixelWrite`=1.
  - DONE: `done`=1, lasts one cycle, then returns to IDLE.
- Accept: in IDLE, `cmdValid && cmdReady` latches all `cmd*` fields. `cmdReady` is 0 in every other state.
- Clipping, computed at accept:
  - xLast = min(cmdX+cmdW, WIDTH)−1.
  - yLast = min(cmdY+cmdH, HEIGHT)−1.
  - Use 9-bit/10-bit intermediates so no wrap occurs.
- Empty command (cmdW==0, cmdH==0, cmdX≥WIDTH or cmdY≥HEIGHT): IDLE→DONE directly, zero pixels issued.
- Non-empty command: IDLE→FILL with xAddr=cmdX, yAddr=cmdY, pixelData=cmdColour.
- Transfer happens on a cycle with `pixelWrite && pixelReady`. Then:
  - xAddr<xLast: xAddr+1.
  - Otherwise: xAddr=cmdX, yAddr+1.
  - Transfer at (xLast, yLast): FILL→DONE, `pixelWrite` deasserts on the following cycle.
- While `pixelWrite`=1 and `pixelReady`=0: xAddr, yAddr and pixelData hold stable. `pixelWrite` never drops before the transfer completes.
- `busy` = state≠IDLE.
- `cmdValid` during FILL/DONE is ignored (not accepted, not queued).

## Timing
- Reset values (asserted asynchronously, immediately):
  - state=IDLE.
  - `cmdReady`=0, `pixelWrite`=0, `busy`=0, `done`=0.
  - xAddr=0, yAddr=0, pixelData=0.
- `cmdReady` rises on the first rising edge after `reset_n` deasserts.
- Accept-to-first-`pixelWrite` latency: 1 cycle.
- With `pixelReady` held 1: one pixel per cycle; N pixels take N cycles in FILL, plus 1 DONE cycle.
- Accept-to-`done` latency: N+1 cycles. Empty command: 1 cycle.
- Back-to-back commands: next accept is possible the cycle after DONE, so there is 1 idle cycle between fills.
- Reset mid-FILL aborts immediately. No `done` pulse; the partial frame is left on the panel.

## Structure
- Package `lt24_pkg`:
  - WIDTH/HEIGHT defaults.
  - Coordinate widths (X_W=8, Y_W=9).
  - `rgb565_t` typedef.
  - FSM state enum (IDLE, FILL, DONE).
- Sub-module `lt24_raster_counter`:
  - Loadable x/y counter with start column, xLast and yLast inputs, and an advance enable.
  - Outputs current x, y and `last` (at xLast,yLast).
- Top holds the FSM, clip arithmetic and handshake.

## Test plan
- Reset then cmd (X=0,Y=0,W=240,H=320,colour 16'hF800), `pixelReady`=1 → 76800 writes, all 16'hF800, raster order, `done` at cycle 76801 after accept.
- Cmd (X=230,Y=315,W=20,H=10) → clipped to 10×5: x 230..239, y 315..319, 50 writes, no address ≥ panel size.
- Cmd (X=5,Y=5,W=3,H=2), `pixelReady` toggling 1,0,1,0 → 6 transfers, address/data stable while stalled, (5,5)…(7,6).
- Cmds W=0; then X=240; then Y=320 → no `pixelWrite`, `done` 1 cycle after each accept.
- `cmdValid` held high during a 4-pixel fill → exactly one accept; second command accepted the cycle after DONE.
- `reset_n` pulsed low mid-fill → `pixelWrite`, `busy` = 0 asynchronously, no `done`; a fresh command afterwards completes normally.
